// File: rtl/sweep_ctrl.sv
// Sequencer for an external up/down counter: loads lo, then sweeps
// between lo and hi a programmed number of times (0 = until stop).
module sweep_ctrl #(
    parameter int WIDTH = 10
) (
    input  logic             clk5m,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       sweeps,
    input  logic [WIDTH-1:0] cnt,
    output logic             load,
    output logic             en,
    output logic             updn,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [3:0]       r_sweeps;
    logic [3:0]       r_swcnt;
    logic             r_err;

    logic             w_go;
    logic             w_reject;
    logic             w_accept;
    logic             w_top;
    logic             w_bot;
    logic [3:0]       w_swinc;
    logic             w_last;

    assign w_go     = (r_state == S_IDLE) && start && !stop;
    assign w_reject = w_go && (lo >= hi);
    assign w_accept = w_go && (lo < hi);

    // Turn one step early: the counter lands on the bound this same edge.
    assign w_top    = (cnt == r_hi - ONE);
    assign w_bot    = (cnt == r_lo + ONE);
    assign w_swinc  = r_swcnt + 4'd1;
    assign w_last   = (r_sweeps != 4'd0) && (w_swinc == r_sweeps);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = stop ? S_IDLE : S_UP;
            end
            S_UP: begin
                if (stop)       w_next = S_IDLE;
                else if (w_top) w_next = S_DOWN;
            end
            S_DOWN: begin
                if (stop)       w_next = S_IDLE;
                else if (w_bot) w_next = w_last ? S_DONE : S_UP;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk5m or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_sweeps <= '0;
            r_swcnt  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_lo     <= lo;
                r_hi     <= hi;
                r_sweeps <= sweeps;
                r_swcnt  <= '0;
            end else if (r_state == S_DOWN && !stop && w_bot) begin
                r_swcnt <= w_swinc;
            end
        end
    end

    assign load    = (r_state == S_LOAD);
    assign en      = (r_state == S_UP) || (r_state == S_DOWN);
    assign updn    = (r_state == S_DOWN);
    assign busy    = load || en;
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
    assign data_in = r_lo;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: drives a behavioural counter from the DUT and
// compares every cycle against a trace computed from lo/hi/sweeps.
module tb_sweep_ctrl;

    localparam int W = 10;

    logic         clk5m = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] lo = '0;
    logic [W-1:0] hi = '0;
    logic [3:0]   sweeps = '0;
    logic [W-1:0] cnt = '0;
    logic         load;
    logic         en;
    logic         updn;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic         err;

    sweep_ctrl #(.WIDTH(W)) dut (
        .clk5m   (clk5m),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .lo      (lo),
        .hi      (hi),
        .sweeps  (sweeps),
        .cnt     (cnt),
        .load    (load),
        .en      (en),
        .updn    (updn),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk5m = ~clk5m;

    // The sequenced counter: load wins over en.
    always @(posedge clk5m) begin
        if (load)    cnt <= data_in;
        else if (en) cnt <= updn ? cnt - 1'b1 : cnt + 1'b1;
    end

    typedef struct {
        logic         ld;
        logic         en;
        logic         ud;
        logic         bz;
        logic         dn;
        logic         er;
        logic [W-1:0] c;
        logic [W-1:0] d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, req);
        end
    endfunction

    function automatic exp_t mk(input bit ld, input bit e, input bit ud,
                                input bit bz, input bit dn, input bit er,
                                input int c, input int d);
        exp_t x;
        x.ld = ld;
        x.en = e;
        x.ud = ud;
        x.bz = bz;
        x.dn = dn;
        x.er = er;
        x.c  = W'(c);
        x.d  = W'(d);
        return x;
    endfunction

    always @(negedge clk5m) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({load, en, updn, busy, done, err, cnt, data_in} !==
                {e.ld, e.en, e.ud, e.bz, e.dn, e.er, e.c, e.d}) begin
                failures++;
                $display("FAIL cycle t=%0t act ld=%b en=%b ud=%b bz=%b dn=%b er=%b cnt=%0d din=%0d exp ld=%b en=%b ud=%b bz=%b dn=%b er=%b cnt=%0d din=%0d",
                         $time, load, en, updn, busy, done, err, cnt, data_in,
                         e.ld, e.en, e.ud, e.bz, e.dn, e.er, e.c, e.d);
            end
        end
    end

    // Expected trace of a run: one load cycle, then per sweep lo..hi-1
    // counting up and hi..lo+1 counting down, then done and idle.
    task automatic gen_run(input int l, input int h, input int nsw,
                           input bit fin, input int maxn);
        exp_t t[$];
        t.push_back(mk(1, 0, 0, 1, 0, 0, m_cnt, l));
        for (int s = 0; s < nsw; s++) begin
            for (int v = l; v < h; v++)
                t.push_back(mk(0, 1, 0, 1, 0, 0, v, l));
            for (int v = h; v > l; v--)
                t.push_back(mk(0, 1, 1, 1, 0, 0, v, l));
        end
        if (fin) begin
            t.push_back(mk(0, 0, 0, 0, 1, 0, l, l));
            t.push_back(mk(0, 0, 0, 0, 0, 0, l, l));
        end
        for (int i = 0; i < t.size() && i < maxn; i++) begin
            q.push_back(t[i]);
            m_cnt = int'(t[i].c);
        end
    endtask

    task automatic idle(input int n, input int c, input int d, input bit er);
        if (er) q.push_back(mk(0, 0, 0, 0, 0, 1, c, d));
        for (int i = 0; i < n; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, c, d));
        m_cnt = c;
    endtask

    task automatic pulse_start(input int l, input int h, input int sw,
                               input bit stp);
        lo     = W'(l);
        hi     = W'(h);
        sweeps = 4'(sw);
        stop   = stp;
        start  = 1'b1;
        @(negedge clk5m);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk5m);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout left=%0d exp=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int  lit[13];
        bit  ok;

        #1;
        chk("rst_load", 32'(load), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_updn", 32'(updn), 0);
        chk("rst_din", 32'(data_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk5m);
        #1;
        rst = 1'b0;
        @(negedge clk5m);
        #1;

        // Basic two-sweep run 5..8
        gen_run(5, 8, 2, 1, 1000);
        lit = '{5, 6, 7, 8, 7, 6, 5, 6, 7, 8, 7, 6, 5};
        ok = 1'b1;
        for (int i = 0; i < 13; i++)
            if (int'(q[i + 1].c) != lit[i]) ok = 1'b0;
        chk("model_pin", 32'(ok), 1);
        pulse_start(5, 8, 2, 0);
        drain(100);
        chk("t1_hold_cnt", 32'(cnt), 5);
        chk("t1_busy", 32'(busy), 0);

        // Rejected starts: equal and inverted bounds
        idle(1, 5, 5, 1);
        pulse_start(9, 9, 2, 0);
        drain(20);
        idle(1, 5, 5, 1);
        pulse_start(10, 3, 2, 0);
        drain(20);

        // start together with stop in idle
        idle(2, 5, 5, 0);
        pulse_start(6, 9, 1, 1);
        drain(20);

        // Minimal range, with start/bounds changes while busy
        gen_run(20, 21, 1, 1, 1000);
        pulse_start(20, 21, 1, 0);
        start  = 1'b1;
        lo     = W'(100);
        hi     = W'(200);
        sweeps = 4'd5;
        @(negedge clk5m);
        #1;
        @(negedge clk5m);
        #1;
        start  = 1'b0;
        lo     = W'(20);
        hi     = W'(21);
        sweeps = 4'd1;
        drain(50);
        chk("t4_cnt", 32'(cnt), 20);

        // Full-range continuous run, stopped in DOWN at 500
        gen_run(0, 1023, 2, 0, 3594);
        pulse_start(0, 1023, 0, 0);
        drain(5000);
        stop = 1'b1;
        idle(2, 499, 0, 0);
        @(negedge clk5m);
        #1;
        stop = 1'b0;
        drain(20);
        chk("t5_cnt", 32'(cnt), 499);

        // Continuous mode past sweep counter wrap
        gen_run(0, 1, 20, 0, 41);
        pulse_start(0, 1, 0, 0);
        drain(100);
        stop = 1'b1;
        idle(2, 0, 0, 0);
        @(negedge clk5m);
        #1;
        stop = 1'b0;
        drain(20);

        // Async reset mid-UP at cnt=6, then a fresh run
        gen_run(5, 8, 2, 1, 3);
        pulse_start(5, 8, 2, 0);
        drain(20);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en", 32'(en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_load", 32'(load), 0);
        chk("arst_din", 32'(data_in), 0);
        @(negedge clk5m);
        #1;
        chk("arst_cnt_hold", 32'(cnt), 6);
        chk("arst_done", 32'(done), 0);
        rst = 1'b0;
        m_cnt = 6;
        @(negedge clk5m);
        #1;
        gen_run(2, 4, 1, 1, 1000);
        pulse_start(2, 4, 1, 0);
        drain(50);
        chk("t7_cnt", 32'(cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, default 10, bit width of the counter datapath being sequenced.
REQ-002 clk5m  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a sweep sequence; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in every state.
REQ-006 lo  input  WIDTH  lower sweep bound, unsigned.
REQ-007 hi  input  WIDTH  upper sweep bound, unsigned.
REQ-008 sweeps  input  4  number of up/down sweeps; 0 = continuous until stop.
REQ-009 cnt  input  WIDTH  counter value fed back from the sequenced counter.
REQ-010 load  output  1  counter parallel-load strobe.
REQ-011 en  output  1  counter count enable.
REQ-012 updn  output  1  counter direction; 0 = up, 1 = down.
REQ-013 data_in  output  WIDTH  counter parallel-load value.
REQ-014 busy  output  1  high in LOAD, UP, DOWN.
REQ-015 done  output  1  one-cycle pulse at normal sequence completion.
REQ-016 err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 Counter contract: loads data_in when load=1 (priority over en); otherwise counts by 1 when en=1, direction per updn; holds when en=0.
REQ-018 FSM states: IDLE, LOAD, UP, DOWN, DONE; load, en, updn, busy, done are decoded from the state register only (Moore).
REQ-019 Outputs per state: LOAD: load=1, en=0; UP: en=1, updn=0; DOWN: en=1, updn=1; IDLE/DONE: load=0, en=0; updn=0 except in DOWN.
REQ-020 data_in shall always equal the captured lo value.
REQ-021 IDLE, start=1, stop=0, lo<hi: capture lo, hi, sweeps into shadow registers, clear sweep counter, go to LOAD.
REQ-022 IDLE, start=1, stop=0, lo>=hi: stay IDLE, pulse err for one cycle.
REQ-023 LOAD -> UP unconditionally after one cycle (unless stop).
REQ-024 UP -> DOWN on the edge where cnt == hi_shadow-1; counter reaches hi on that same edge.
REQ-025 DOWN, cnt == lo_shadow+1: increment sweep counter; if sweeps_shadow != 0 and incremented count == sweeps_shadow go to DONE, else go to UP.
REQ-026 One sweep lasts 2*(hi-lo) cycles; counter never leaves range [lo, hi].
REQ-027 DONE -> IDLE after exactly one cycle; done=1 only in DONE.
REQ-028 stop=1 in LOAD, UP or DOWN: next state IDLE, no done pulse; stop has priority over every other transition.
REQ-029 stop=1 and start=1 together in IDLE: stay IDLE, no err.
REQ-030 start while busy or in DONE shall be ignored; lo, hi, sweeps changes while busy have no effect.
REQ-031 Sweep counter is 4 bits; in continuous mode (sweeps=0) it wraps 15 -> 0 without effect on sequencing.

Reset
REQ-032 rst=1 shall immediately force state IDLE, load=0, en=0, updn=0, data_in=0, busy=0, done=0, err=0, shadow registers and sweep counter to 0, regardless of clock.
REQ-033 Reset asserted mid-sequence shall abort it without a done pulse; after deassertion the block waits for a new start.

Verification
REQ-034 lo=5, hi=8, sweeps=2, start pulse -> one cycle load=1 with data_in=5, then cnt 5,6,7,8,7,6,5,6,7,8,7,6,5, done pulse, busy low, cnt holds 5.
REQ-035 lo=0, hi=1023, sweeps=0 -> cnt reaches 1023, turns down without wrap to 0, continues sweeping; stop in DOWN at cnt=500 -> en=0 next cycle, cnt holds 499, no done.
REQ-036 lo=9, hi=9 and lo=10, hi=3 start -> err one-cycle pulse each, busy stays 0, load never asserted.
REQ-037 lo=20, hi=21, sweeps=1 -> cnt 20,21,20, done; second start during busy and lo change to 100 mid-run -> ignored.
REQ-038 Async rst asserted between clock edges in UP at cnt=6 -> en, busy drop immediately; after release, start with lo=2, hi=4, sweeps=1 -> cnt 2,3,4,3,2, done.
REQ-039 start=1 and stop=1 in same IDLE cycle -> no state change, no err, no load.
